// File: rtl/pe_array_ctrl.sv
// Sequencer for a ROW_NUM x COLUMN_NUM unary PE array: weight load, unary compute, drain.
// Optional weight reuse (skip W_LOAD on request) is enabled by defining PE_ARRAY_CTRL_WEIGHT_REUSE_EN.
module pe_array_ctrl #(
    parameter int ROW_NUM                = 4,
    parameter int COLUMN_NUM             = 4,
    parameter int BINARY_WEIGHT_BITWIDTH = 4,
    parameter int M_END_BITWIDTH         = 8
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic                                              start,
    input  logic [M_END_BITWIDTH-1:0]                         m_rows,
    input  logic                                              stall,
`ifdef PE_ARRAY_CTRL_WEIGHT_REUSE_EN
    input  logic                                              reuse_weights,
`endif
    output logic                                              busy,
    output logic                                              done,
    output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]                weight_reg_en,
    output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]                weight_reg_r0w1,
    output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]                input_reg_en,
    output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]                input_reg_r0w1,
    output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]                rand_num_reg_en,
    output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]                rand_num_reg_r0w1,
    output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]                output_num_reg_en,
    output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]                output_num_reg_r0w1,
    output logic [ROW_NUM-1:0][M_END_BITWIDTH-1:0]            M_end,
    output logic [((ROW_NUM > 1) ? $clog2(ROW_NUM) : 1)-1:0]  w_row_idx,
    output logic [M_END_BITWIDTH-1:0]                         in_row_idx,
    output logic [BINARY_WEIGHT_BITWIDTH-1:0]                 unary_cnt
);

    localparam int WIW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int DW  = (COLUMN_NUM > 1) ? $clog2(COLUMN_NUM) : 1;
    localparam int BW  = BINARY_WEIGHT_BITWIDTH;
    localparam int MW  = M_END_BITWIDTH;

    typedef enum logic [2:0] {IDLE, W_LOAD, COMPUTE, DRAIN, DONE} state_t;

    typedef logic [ROW_NUM-1:0][COLUMN_NUM-1:0] grid_t;

    state_t                       state, state_n;
    logic [WIW-1:0]               w_row_n;
    logic [MW-1:0]                in_row_n;
    logic [BW-1:0]                unary_n;
    logic [DW-1:0]                drain_cnt, drain_n;
    logic [ROW_NUM-1:0][MW-1:0]   m_end_n;
    grid_t                        wgt_q, inp_q, rnd_q, out_q;
    grid_t                        wgt_n, inp_n, rnd_n, out_n;

    always_comb begin
        state_n  = state;
        w_row_n  = w_row_idx;
        in_row_n = in_row_idx;
        unary_n  = unary_cnt;
        drain_n  = drain_cnt;
        m_end_n  = M_end;
        case (state)
            IDLE: begin
                if (start) begin
                    if (m_rows == '0) begin
                        state_n = DONE;
                    end else begin
                        for (int r = 0; r < ROW_NUM; r++) m_end_n[r] = m_rows - MW'(1);
                        w_row_n  = '0;
                        in_row_n = '0;
                        unary_n  = '0;
                        drain_n  = '0;
`ifdef PE_ARRAY_CTRL_WEIGHT_REUSE_EN
                        state_n  = reuse_weights ? COMPUTE : W_LOAD;
`else
                        state_n  = W_LOAD;
`endif
                    end
                end
            end
            W_LOAD: begin
                if (!stall) begin
                    if (w_row_idx == WIW'(ROW_NUM - 1)) begin
                        state_n = COMPUTE;
                        w_row_n = '0;
                    end else begin
                        w_row_n = w_row_idx + WIW'(1);
                    end
                end
            end
            COMPUTE: begin
                // M_end rows are all equal, so row 0 serves as the job's last input index
                if (!stall) begin
                    if (unary_cnt == {BW{1'b1}}) begin
                        unary_n = '0;
                        if (in_row_idx == M_end[0]) begin
                            state_n  = DRAIN;
                            in_row_n = '0;
                        end else begin
                            in_row_n = in_row_idx + MW'(1);
                        end
                    end else begin
                        unary_n = unary_cnt + BW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (drain_cnt == DW'(COLUMN_NUM - 1)) begin
                        state_n = DONE;
                        drain_n = '0;
                    end else begin
                        drain_n = drain_cnt + DW'(1);
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Enable patterns are decoded from the next state so they line up with the registered counters
    always_comb begin
        wgt_n = '0;
        inp_n = '0;
        rnd_n = '0;
        out_n = '0;
        case (state_n)
            W_LOAD: begin
                for (int r = 0; r < ROW_NUM; r++)
                    if (w_row_n == WIW'(r)) wgt_n[r] = '1;
            end
            COMPUTE: begin
                for (int r = 0; r < ROW_NUM; r++) begin
                    rnd_n[r][0] = 1'b1;
                    inp_n[r][0] = (unary_n == '0);
                end
            end
            DRAIN:   out_n = '1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            w_row_idx  <= '0;
            in_row_idx <= '0;
            unary_cnt  <= '0;
            drain_cnt  <= '0;
            M_end      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wgt_q      <= '0;
            inp_q      <= '0;
            rnd_q      <= '0;
            out_q      <= '0;
        end else begin
            state      <= state_n;
            w_row_idx  <= w_row_n;
            in_row_idx <= in_row_n;
            unary_cnt  <= unary_n;
            drain_cnt  <= drain_n;
            M_end      <= m_end_n;
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
            wgt_q      <= wgt_n;
            inp_q      <= inp_n;
            rnd_q      <= rnd_n;
            out_q      <= out_n;
        end
    end

    // While stalled the registers hold the frozen cycle; stall masks it so no PE moves data twice
    assign weight_reg_en       = stall ? '0 : wgt_q;
    assign weight_reg_r0w1     = stall ? '0 : wgt_q;
    assign input_reg_en        = stall ? '0 : inp_q;
    assign input_reg_r0w1      = stall ? '0 : inp_q;
    assign rand_num_reg_en     = stall ? '0 : rnd_q;
    assign rand_num_reg_r0w1   = stall ? '0 : rnd_q;
    assign output_num_reg_en   = stall ? '0 : out_q;
    assign output_num_reg_r0w1 = stall ? '0 : out_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
module tb_pe_array_ctrl;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int BW = 4;
    localparam int MW = 8;

    logic clk = 1'b0, resetn = 1'b0, start = 1'b0, stall = 1'b0;
    logic [MW-1:0] m_rows = '0;
`ifdef PE_ARRAY_CTRL_WEIGHT_REUSE_EN
    logic reuse_weights = 1'b0;
`endif
    logic busy, done;
    logic [R-1:0][C-1:0] wen, wrw, ien, irw, ren, rrw, oen, orw;
    logic [R-1:0][MW-1:0] m_end;
    logic [1:0]    w_row_idx;
    logic [MW-1:0] in_row_idx;
    logic [BW-1:0] unary_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    pe_array_ctrl #(
        .ROW_NUM(R), .COLUMN_NUM(C), .BINARY_WEIGHT_BITWIDTH(BW), .M_END_BITWIDTH(MW)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .m_rows(m_rows), .stall(stall),
`ifdef PE_ARRAY_CTRL_WEIGHT_REUSE_EN
        .reuse_weights(reuse_weights),
`endif
        .busy(busy), .done(done),
        .weight_reg_en(wen), .weight_reg_r0w1(wrw),
        .input_reg_en(ien), .input_reg_r0w1(irw),
        .rand_num_reg_en(ren), .rand_num_reg_r0w1(rrw),
        .output_num_reg_en(oen), .output_num_reg_r0w1(orw),
        .M_end(m_end), .w_row_idx(w_row_idx), .in_row_idx(in_row_idx), .unary_cnt(unary_cnt)
    );

    always #5 clk = ~clk;

`define CHK(tag, obs, exp) begin \
    n_cmp++; \
    assert ((obs) === (exp)) else begin \
        n_fail++; \
        $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
end

    task automatic chk_zero(input string tag, input logic [127:0] obs);
        n_cmp++;
        if (obs !== 128'd0) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected 0", tag, obs);
        end
    endtask

    task automatic check_quiet(input string ctx);
        chk_zero({ctx, " busy"}, 128'(busy));
        chk_zero({ctx, " done"}, 128'(done));
        chk_zero({ctx, " unary_cnt"}, 128'(unary_cnt));
        chk_zero({ctx, " in_row_idx"}, 128'(in_row_idx));
        chk_zero({ctx, " w_row_idx"}, 128'(w_row_idx));
        chk_zero({ctx, " enables"}, {wen, wrw, ien, irw, ren, rrw, oen, orw});
    endtask

    task automatic run_job(input int m, input int s, input int L, input int ncyc, input bit disturb);
        int ce, e;
        bit wl, cp, dr, dn, g;
        logic [15:0] xw, xi, xr, xo;
        m_rows = MW'(m);
        start  = 1'b1;
        ce     = 4 + 16 * m;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            start = disturb && (k == 8);
            if (disturb && k == 3) m_rows = 8'd7;
            stall = (k >= s) && (k < s + L);
            #1;
            e  = (k < s) ? k : ((k < s + L) ? s : k - L);
            wl = (m > 0) && (e >= 1) && (e <= 4);
            cp = (m > 0) && (e >= 5) && (e <= ce);
            dr = (m > 0) && (e > ce) && (e <= ce + 4);
            dn = (m > 0) ? (e == ce + 5) : (e == 1);
            g  = stall && (wl || cp || dr);
            xw = (wl && !g) ? (16'hF << (4 * (e - 1))) : 16'h0;
            xi = (cp && !g && ((e - 5) % 16 == 0)) ? 16'h1111 : 16'h0;
            xr = (cp && !g) ? 16'h1111 : 16'h0;
            xo = (dr && !g) ? 16'hFFFF : 16'h0;
            `CHK("busy", busy, (wl | cp | dr | dn))
            `CHK("done", done, dn)
            `CHK("w_row_idx", w_row_idx, (wl ? 2'(e - 1) : 2'd0))
            `CHK("unary_cnt", unary_cnt, (cp ? BW'((e - 5) % 16) : 4'd0))
            `CHK("in_row_idx", in_row_idx, (cp ? MW'((e - 5) / 16) : 8'd0))
            `CHK("weight_reg_en", wen, xw)
            `CHK("weight_reg_r0w1", wrw, xw)
            `CHK("input_reg_en", ien, xi)
            `CHK("input_reg_r0w1", irw, xi)
            `CHK("rand_num_reg_en", ren, xr)
            `CHK("rand_num_reg_r0w1", rrw, xr)
            `CHK("output_num_reg_en", oen, xo)
            `CHK("output_num_reg_r0w1", orw, xo)
        end
        stall = 1'b0;
        start = 1'b0;
        if (m > 0) `CHK("M_end", m_end, {R{MW'(m - 1)}})
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        chk_zero("reset M_end", 128'(m_end));
        resetn = 1'b1;
        @(posedge clk); #1;
        stall = 1'b1;
        @(posedge clk); #1;
        stall = 1'b0;
        #1;
        check_quiet("idle stall");

        run_job(2, 0, 0, 42, 1'b1);
        run_job(2, 10, 3, 45, 1'b0);
        run_job(0, 0, 0, 3, 1'b0);
        run_job(1, 2, 2, 28, 1'b0);

        run_job(2, 0, 0, 20, 1'b0);
        resetn = 1'b0;
        #1;
        check_quiet("mid-job reset");
        chk_zero("mid-job reset M_end", 128'(m_end));
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            check_quiet("post reset");
        end
        run_job(2, 0, 0, 42, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        if (n_fail != 0) $error("FAIL summary: %0d mismatches", n_fail);
        $finish;
    end
endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 SHALL take parameter ROW_NUM, default 4: PE array rows.
REQ-002 SHALL take parameter COLUMN_NUM, default 4: PE array columns.
REQ-003 SHALL take parameter BINARY_WEIGHT_BITWIDTH, default 4: unary compute window per input row, U = 2**BINARY_WEIGHT_BITWIDTH cycles.
REQ-004 SHALL take parameter M_END_BITWIDTH, default 8: width of input-row count and index.
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port start  in  1  job request, sampled only in IDLE.
REQ-008 SHALL have port m_rows  in  M_END_BITWIDTH  input matrix height for the job, latched on accepted start.
REQ-009 SHALL have port stall  in  1  freeze request from the buffers.
REQ-010 SHALL have port busy  out  1  high in any state except IDLE.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports weight_reg_en, weight_reg_r0w1, input_reg_en, input_reg_r0w1, rand_num_reg_en, rand_num_reg_r0w1, output_num_reg_en, output_num_reg_r0w1  out  ROW_NUM x COLUMN_NUM each  PE register controls.
REQ-013 SHALL have port M_end  out  ROW_NUM x M_END_BITWIDTH  per-row last input index.
REQ-014 SHALL have port w_row_idx  out  clog2(ROW_NUM)  weight buffer row address.
REQ-015 SHALL have port in_row_idx  out  M_END_BITWIDTH  input buffer row address.
REQ-016 SHALL have port unary_cnt  out  BINARY_WEIGHT_BITWIDTH  cycle within unary window.

Function
REQ-017 SHALL implement states IDLE, W_LOAD, COMPUTE, DRAIN, DONE; all outputs registered.
REQ-018 IDLE: start=1 with m_rows>0 -> W_LOAD next cycle; m_rows, M_end[r]=m_rows-1 for all r latched; start with m_rows=0 -> DONE directly.
REQ-019 W_LOAD: ROW_NUM cycles, w_row_idx counts 0..ROW_NUM-1; row w_row_idx has weight_reg_en and weight_reg_r0w1 all ones, all other bits zero; after last row -> COMPUTE.
REQ-020 COMPUTE: m_rows*U cycles; unary_cnt counts 0..U-1, wraps to 0 while in_row_idx increments.
REQ-021 COMPUTE, unary_cnt==0: input_reg_en[r][0] and input_reg_r0w1[r][0]=1 for all r; otherwise input controls zero.
REQ-022 COMPUTE, every cycle: rand_num_reg_en[r][0] and rand_num_reg_r0w1[r][0]=1 for all r.
REQ-023 After unary_cnt==U-1 with in_row_idx==m_rows-1 -> DRAIN.
REQ-024 DRAIN: COLUMN_NUM cycles, output_num_reg_en and output_num_reg_r0w1 all ones (partial-sum passby); then DONE.
REQ-025 DONE: one cycle, done=1, busy=1, -> IDLE.
REQ-026 stall=1 in W_LOAD/COMPUTE/DRAIN: state and all counters hold, all en/r0w1 outputs zero; resumes exactly where frozen when stall drops. stall ignored in IDLE/DONE.
REQ-027 start while busy SHALL be ignored; m_rows changes while busy SHALL not affect the job.
REQ-028 Busy length without stall SHALL be ROW_NUM + m_rows*U + COLUMN_NUM + 1 cycles.

Reset
REQ-029 resetn low SHALL immediately force IDLE; all counters, indices, M_end, busy, done and every en/r0w1 bit to 0, including mid-job.
REQ-030 After resetn rises, no job SHALL run until a new start.

Configuration
REQ-031 Macro PE_ARRAY_CTRL_WEIGHT_REUSE_EN defined: extra input reuse_weights (1 bit, sampled with start); start with reuse_weights=1 skips W_LOAD, IDLE -> COMPUTE; busy length reduces by ROW_NUM.
REQ-032 Macro undefined: port reuse_weights absent; every job runs W_LOAD.

Verification
REQ-033 Defaults, start at cycle 0, m_rows=2 -> W_LOAD cycles 1-4 (w_row_idx 0..3), COMPUTE 5-36, input_reg_en column 0 at cycles 5 and 21, DRAIN 37-40, done at 41, IDLE at 42, M_end all rows =1.
REQ-034 stall high cycles 10-12 of the above job -> enables zero in 10-12, unary_cnt holds, done moves to cycle 44.
REQ-035 resetn low at cycle 20 mid-COMPUTE -> all outputs 0 immediately; a new start after release runs a full job from W_LOAD.
REQ-036 start with m_rows=0 -> no enables asserted, done at cycle 1, busy only in cycle 1.
REQ-037 Second start pulse at cycle 8 while busy -> ignored, single done at 41.
REQ-038 With PE_ARRAY_CTRL_WEIGHT_REUSE_EN, reuse_weights=1, m_rows=1 -> no weight_reg_en asserted, COMPUTE cycles 1-16, DRAIN 17-20, done at 21.
